blvds_frame_rx: RTL

Receive-side parser for the 18-bit BLVDS word stream that `user_bcvs` produces. It sits on `oUser_data` in the simulation top, parallel to `BLVDS_uPP_TOP`. It delineates frames, latches the header fields, emits the 32-bit Im/Re samples, and checks frame length and checksum. The error and frame counters are exported for SignalTap/ISSP readback.

---
 rtl/blvds_pkg.sv | 28 ++
 rtl/blvds_idle_timer.sv | 31 +++
 rtl/blvds_frame_rx.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/blvds_pkg.sv
// Shared types and constants for the BLVDS frame receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package blvds_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2,
    ST_CHK  = 2'd3
  } rxState_e;

  localparam logic [2:0] ERR_NONE      = 3'd0;
  localparam logic [2:0] ERR_CHECKSUM  = 3'd1;
  localparam logic [2:0] ERR_EARLY_SOF = 3'd2;
  localparam logic [2:0] ERR_LENGTH    = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT   = 3'd4;

  localparam int HDR_WORDS = 8;
  localparam int VALID_BIT = 17;
  localparam int SOF_BIT   = 16;

  // Saturating increment for the readback counters
  function automatic logic [15:0] satInc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/blvds_idle_timer.sv
// Idle-gap counter: measures cycles without a valid word while a frame is open.
// Latency: oExpire is combinational on the idle cycle that makes the gap exceed TIMEOUT.
// Backpressure: none; the count just follows the input stream.
module blvds_idle_timer #(
  parameter logic [15:0] TIMEOUT = 16'd1000
) (
  input  logic iclk,
  input  logic ireset,
  input  logic iRun,
  input  logic iStart,
  input  logic iKick,
  output logic oExpire
);

  logic [15:0] gapCnt;

  // Restart on every accepted word; hold at TIMEOUT so the count never wraps
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      gapCnt <= '0;
    end else if (!iRun || iStart || iKick) begin
      gapCnt <= '0;
    end else if (gapCnt != TIMEOUT) begin
      gapCnt <= gapCnt + 16'd1;
    end
  end

  // TIMEOUT idle cycles are tolerated; the next idle cycle is one too many
  assign oExpire = iRun && !iStart && !iKick && (gapCnt == TIMEOUT);

endmodule

// File: rtl/blvds_frame_rx.sv
// Parses the 18-bit BLVDS word stream into header fields and 32-bit samples, checks length and checksum.
// Latency: every output is registered one cycle after the word (or idle cycle) that decides it.
// Backpressure: none; a valid word is accepted every cycle, words with the valid flag clear are skipped.
module blvds_frame_rx
  import blvds_pkg::*;
#(
  parameter logic [15:0] MAX_SAMPLES = 16'd4096,
  parameter logic [15:0] TIMEOUT     = 16'd1000
) (
  input  logic        iclk,
  input  logic        ireset,
  input  logic [17:0] iDATA_BLVDS,
  output logic [7:0]  oNUM_PACK,
  output logic [7:0]  oSIZE_PACK,
  output logic [15:0] oNUM_OI,
  output logic [15:0] oNUM_TIR,
  output logic [15:0] oBCUR,
  output logic [15:0] oICUR,
  output logic [31:0] oLPPS,
  output logic [31:0] oARUSH,
  output logic        oHDR_VAL,
  output logic [31:0] oSAMPLE,
  output logic        oSAMPLE_VAL,
  output logic        oFRAME_DONE,
  output logic        oFRAME_ERR,
  output logic [2:0]  oERR_CODE,
  output logic [15:0] oFRAME_CNT,
  output logic [15:0] oERR_CNT
);

  logic        wordVld;
  logic        sofWord;
  logic [15:0] wordDat;

  assign wordVld = iDATA_BLVDS[VALID_BIT];
  assign sofWord = wordVld & iDATA_BLVDS[SOF_BIT];
  assign wordDat = iDATA_BLVDS[15:0];

  rxState_e    state;
  rxState_e    stateNext;

  logic [2:0]  hdrIdx;
  logic [7:0]  numPackSh;
  logic [7:0]  sizePackSh;
  logic [15:0] numOiSh;
  logic [15:0] numTirSh;
  logic [15:0] bcurSh;
  logic [31:0] lppsSh;
  logic [31:0] arushSh;
  logic [15:0] runSum;
  logic [15:0] firstHalf;
  logic [16:0] payCnt;

  logic [15:0] nProd;
  logic [16:0] payLast;
  logic        timeoutHit;

  logic        hdrDone;
  logic        payWord;
  logic        sampleDone;
  logic        frameOk;
  logic        abort;
  logic [2:0]  abortCode;

  // Sample count from the shadowed w0; stable from w0 until the next SOF
  assign nProd   = 16'(numPackSh) * 16'(sizePackSh);
  assign payLast = {nProd, 1'b0} - 17'd1;

  blvds_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) uIdleTimer (
    .iclk    (iclk),
    .ireset  (ireset),
    .iRun    (state != ST_IDLE),
    .iStart  (sofWord),
    .iKick   (wordVld),
    .oExpire (timeoutHit)
  );

  // State register
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state <= ST_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next state and per-word decisions; SOF takes priority so an early SOF restarts a frame
  always_comb begin
    stateNext  = state;
    hdrDone    = 1'b0;
    payWord    = 1'b0;
    sampleDone = 1'b0;
    frameOk    = 1'b0;
    abort      = 1'b0;
    abortCode  = ERR_NONE;
    if (state == ST_IDLE) begin
      if (sofWord) begin
        stateNext = ST_HDR;
      end
    end else if (sofWord) begin
      abort     = 1'b1;
      abortCode = ERR_EARLY_SOF;
      stateNext = ST_HDR;
    end else if (timeoutHit) begin
      abort     = 1'b1;
      abortCode = ERR_TIMEOUT;
      stateNext = ST_IDLE;
    end else if (wordVld) begin
      case (state)
        ST_HDR: begin
          if (hdrIdx == 3'(HDR_WORDS - 1)) begin
            hdrDone = 1'b1;
            if ((nProd == 16'd0) || (nProd > MAX_SAMPLES)) begin
              abort     = 1'b1;
              abortCode = ERR_LENGTH;
              stateNext = ST_IDLE;
            end else begin
              stateNext = ST_PAY;
            end
          end
        end
        ST_PAY: begin
          payWord    = 1'b1;
          sampleDone = payCnt[0];
          if (payCnt == payLast) begin
            stateNext = ST_CHK;
          end
        end
        ST_CHK: begin
          if (wordDat == runSum) begin
            frameOk = 1'b1;
          end else begin
            abort     = 1'b1;
            abortCode = ERR_CHECKSUM;
          end
          stateNext = ST_IDLE;
        end
        default: stateNext = ST_IDLE;
      endcase
    end
  end

  // Header shadows, running checksum and payload word bookkeeping
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      hdrIdx     <= '0;
      numPackSh  <= '0;
      sizePackSh <= '0;
      numOiSh    <= '0;
      numTirSh   <= '0;
      bcurSh     <= '0;
      lppsSh     <= '0;
      arushSh    <= '0;
      runSum     <= '0;
      firstHalf  <= '0;
      payCnt     <= '0;
    end else if (sofWord) begin
      numPackSh  <= wordDat[15:8];
      sizePackSh <= wordDat[7:0];
      runSum     <= wordDat;
      hdrIdx     <= '0;
      payCnt     <= '0;
    end else if (wordVld && (state == ST_HDR)) begin
      runSum <= runSum + wordDat;
      hdrIdx <= hdrIdx + 3'd1;
      case (hdrIdx)
        3'd0:    numOiSh        <= wordDat;
        3'd1:    numTirSh       <= wordDat;
        3'd2:    lppsSh[31:16]  <= wordDat;
        3'd3:    lppsSh[15:0]   <= wordDat;
        3'd4:    arushSh[31:16] <= wordDat;
        3'd5:    arushSh[15:0]  <= wordDat;
        3'd6:    bcurSh         <= wordDat;
        default: ;
      endcase
    end else if (payWord) begin
      runSum <= runSum + wordDat;
      payCnt <= payCnt + 17'd1;
      if (!payCnt[0]) begin
        firstHalf <= wordDat;
      end
    end
  end

  // Registered outputs; header fields only change on a completed header
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      oNUM_PACK   <= '0;
      oSIZE_PACK  <= '0;
      oNUM_OI     <= '0;
      oNUM_TIR    <= '0;
      oBCUR       <= '0;
      oICUR       <= '0;
      oLPPS       <= '0;
      oARUSH      <= '0;
      oHDR_VAL    <= 1'b0;
      oSAMPLE     <= '0;
      oSAMPLE_VAL <= 1'b0;
      oFRAME_DONE <= 1'b0;
      oFRAME_ERR  <= 1'b0;
      oERR_CODE   <= ERR_NONE;
      oFRAME_CNT  <= '0;
      oERR_CNT    <= '0;
    end else begin
      oHDR_VAL    <= hdrDone;
      oSAMPLE_VAL <= sampleDone;
      oFRAME_DONE <= frameOk;
      oFRAME_ERR  <= abort;
      if (hdrDone) begin
        oNUM_PACK  <= numPackSh;
        oSIZE_PACK <= sizePackSh;
        oNUM_OI    <= numOiSh;
        oNUM_TIR   <= numTirSh;
        oLPPS      <= lppsSh;
        oARUSH     <= arushSh;
        oBCUR      <= bcurSh;
        oICUR      <= wordDat;
      end
      if (sampleDone) begin
        oSAMPLE <= {firstHalf, wordDat};
      end
      if (frameOk) begin
        oFRAME_CNT <= satInc(oFRAME_CNT);
      end
      if (abort) begin
        oERR_CODE <= abortCode;
        oERR_CNT  <= satInc(oERR_CNT);
      end
    end
  end

endmodule
